// File: rtl/axi_slice_dc_isolate_ctrl_if.sv
// Handshake bundle between the upstream AXI master side, the isolation
// controller and the dual-clock slave slice (all signals in the slave clock domain).
//
// Valid/ready semantics: a transfer happens on a rising clock edge where valid
// and ready are both high. Once a valid has been presented to the slice it stays
// high until the matching ready, and the payload does not change meanwhile.
// *_i signals are driven into the controller and *_o signals are driven out of it.
interface axi_slice_dc_isolate_ctrl_if;
    logic aw_valid_i;
    logic aw_ready_o;
    logic aw_valid_o;
    logic aw_ready_i;
    logic ar_valid_i;
    logic ar_ready_o;
    logic ar_valid_o;
    logic ar_ready_i;
    logic w_valid_i;
    logic w_ready_o;
    logic w_valid_o;
    logic w_ready_i;
    logic w_last_i;
    logic b_valid_i;
    logic b_ready_i;
    logic r_valid_i;
    logic r_ready_i;
    logic r_last_i;

    modport slave (
        input  aw_valid_i, aw_ready_i, ar_valid_i, ar_ready_i,
        input  w_valid_i, w_ready_i, w_last_i,
        input  b_valid_i, b_ready_i, r_valid_i, r_ready_i, r_last_i,
        output aw_ready_o, aw_valid_o, ar_ready_o, ar_valid_o,
        output w_ready_o, w_valid_o
    );

    modport master (
        output aw_valid_i, aw_ready_i, ar_valid_i, ar_ready_i,
        output w_valid_i, w_ready_i, w_last_i,
        output b_valid_i, b_ready_i, r_valid_i, r_ready_i, r_last_i,
        input  aw_ready_o, aw_valid_o, ar_ready_o, ar_valid_o,
        input  w_ready_o, w_valid_o
    );
endinterface

// File: rtl/axi_slice_dc_isolate_ctrl.sv
// Drain/isolation controller in front of the dual-clock AXI slave slice: gates new
// requests on isolate request, waits for outstanding bursts to drain, then isolates.
module axi_slice_dc_isolate_ctrl #(
    parameter  int MAX_OUTSTANDING = 16,
    localparam int CW              = $clog2(MAX_OUTSTANDING + 1),
    localparam int PW              = CW + 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 isolate_req_i,
    output logic                 isolate_o,
    output logic                 isolated_o,
    axi_slice_dc_isolate_ctrl_if.slave bus,
    output logic [1:0]           dbg_state_o,
    output logic [CW-1:0]        dbg_wr_cnt_o,
    output logic [CW-1:0]        dbg_rd_cnt_o,
    output logic signed [PW-1:0] dbg_wpend_o
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_DRAIN    = 2'd1;
    localparam logic [1:0] ST_ISOLATED = 2'd2;

    localparam logic [CW-1:0]        MAX_CNT = CW'(MAX_OUTSTANDING);
    localparam logic signed [PW-1:0] W_ONE   = PW'(1);

    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic [CW-1:0]        wr_cnt;
    logic [CW-1:0]        wr_cnt_nxt;
    logic [CW-1:0]        rd_cnt;
    logic [CW-1:0]        rd_cnt_nxt;
    logic signed [PW-1:0] wpend;
    logic signed [PW-1:0] wpend_nxt;
    logic                 hold_aw;
    logic                 hold_ar;
    logic                 hold_w;
    logic                 pass_aw;
    logic                 pass_ar;
    logic                 pass_w;
    logic                 aw_hs;
    logic                 ar_hs;
    logic                 w_last_hs;
    logic                 b_hs;
    logic                 r_last_hs;
    logic                 wr_room;
    logic                 rd_room;
    logic                 wpend_pos;
    logic                 drained;

    assign wr_room   = (wr_cnt < MAX_CNT);
    assign rd_room   = (rd_cnt < MAX_CNT);
    // W data still owed for an accepted AW; negative wpend means W ran ahead of AW.
    assign wpend_pos = !wpend[PW-1] && (wpend != '0);

    always_comb begin
        pass_aw = 1'b0;
        pass_ar = 1'b0;
        pass_w  = 1'b0;
        case (state)
            ST_RUN: begin
                pass_aw = wr_room | hold_aw;
                pass_ar = rd_room | hold_ar;
                pass_w  = 1'b1;
            end
            ST_DRAIN: begin
                pass_aw = hold_aw;
                pass_ar = hold_ar;
                pass_w  = wpend_pos | hold_w;
            end
            default: begin
                pass_aw = 1'b0;
                pass_ar = 1'b0;
                pass_w  = 1'b0;
            end
        endcase
    end

    assign bus.aw_valid_o = bus.aw_valid_i & pass_aw;
    assign bus.aw_ready_o = bus.aw_ready_i & pass_aw;
    assign bus.ar_valid_o = bus.ar_valid_i & pass_ar;
    assign bus.ar_ready_o = bus.ar_ready_i & pass_ar;
    assign bus.w_valid_o  = bus.w_valid_i & pass_w;
    assign bus.w_ready_o  = bus.w_ready_i & pass_w;

    assign aw_hs     = bus.aw_valid_o & bus.aw_ready_i;
    assign ar_hs     = bus.ar_valid_o & bus.ar_ready_i;
    assign w_last_hs = bus.w_valid_o & bus.w_ready_i & bus.w_last_i;
    assign b_hs      = bus.b_valid_i & bus.b_ready_i;
    assign r_last_hs = bus.r_valid_i & bus.r_ready_i & bus.r_last_i;

    // A decrement from zero is a protocol error; the counters saturate rather than wrap.
    always_comb begin
        wr_cnt_nxt = wr_cnt;
        if (aw_hs && !b_hs) begin
            wr_cnt_nxt = wr_cnt + 1'b1;
        end else if (!aw_hs && b_hs && (wr_cnt != '0)) begin
            wr_cnt_nxt = wr_cnt - 1'b1;
        end

        rd_cnt_nxt = rd_cnt;
        if (ar_hs && !r_last_hs) begin
            rd_cnt_nxt = rd_cnt + 1'b1;
        end else if (!ar_hs && r_last_hs && (rd_cnt != '0)) begin
            rd_cnt_nxt = rd_cnt - 1'b1;
        end

        wpend_nxt = wpend;
        if (aw_hs && !w_last_hs) begin
            wpend_nxt = wpend + W_ONE;
        end else if (!aw_hs && w_last_hs) begin
            wpend_nxt = wpend - W_ONE;
        end
    end

    assign drained = (wr_cnt == '0) && (rd_cnt == '0) && (wpend == '0) &&
                     !hold_aw && !hold_ar && !hold_w;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (isolate_req_i) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!isolate_req_i) state_nxt = ST_RUN;
                else if (drained)   state_nxt = ST_ISOLATED;
            end
            ST_ISOLATED: begin
                if (!isolate_req_i) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ST_RUN;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            wpend      <= '0;
            hold_aw    <= 1'b0;
            hold_ar    <= 1'b0;
            hold_w     <= 1'b0;
            isolate_o  <= 1'b0;
            isolated_o <= 1'b0;
        end else begin
            state      <= state_nxt;
            wr_cnt     <= wr_cnt_nxt;
            rd_cnt     <= rd_cnt_nxt;
            wpend      <= wpend_nxt;
            // A request already shown to the slice keeps its pass until accepted.
            hold_aw    <= bus.aw_valid_o & ~bus.aw_ready_i;
            hold_ar    <= bus.ar_valid_o & ~bus.ar_ready_i;
            hold_w     <= bus.w_valid_o & ~bus.w_ready_i;
            isolate_o  <= (state_nxt == ST_ISOLATED);
            isolated_o <= (state_nxt == ST_ISOLATED);
        end
    end

    assign dbg_state_o  = state;
    assign dbg_wr_cnt_o = wr_cnt;
    assign dbg_rd_cnt_o = rd_cnt;
    assign dbg_wpend_o  = wpend;

    a_no_b_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(b_hs && !aw_hs && (wr_cnt == '0)))
        else $error("B response with no outstanding write burst");

    a_no_r_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(r_last_hs && !ar_hs && (rd_cnt == '0)))
        else $error("R last with no outstanding read burst");

endmodule

// File: tb/tb_axi_slice_dc_isolate_ctrl.sv
// Bench for axi_slice_dc_isolate_ctrl: directed scenarios plus a short random
// phase, checked every cycle against a queue-based behavioural model.
module tb_axi_slice_dc_isolate_ctrl;
    localparam int MAX = 4;
    localparam int CW  = 3;
    localparam int PW  = 5;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                 isolate_req;
    logic                 isolate_o;
    logic                 isolated_o;
    logic [1:0]           dbg_state;
    logic [CW-1:0]        dbg_wr;
    logic [CW-1:0]        dbg_rd;
    logic signed [PW-1:0] dbg_wp;

    axi_slice_dc_isolate_ctrl_if bus ();

    axi_slice_dc_isolate_ctrl #(.MAX_OUTSTANDING(MAX)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .isolate_req_i (isolate_req),
        .isolate_o     (isolate_o),
        .isolated_o    (isolated_o),
        .bus           (bus.slave),
        .dbg_state_o   (dbg_state),
        .dbg_wr_cnt_o  (dbg_wr),
        .dbg_rd_cnt_o  (dbg_rd),
        .dbg_wpend_o   (dbg_wp)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // behavioural model: outstanding bursts as queues of tags
    typedef enum int {M_RUN, M_DRAIN, M_ISO} mode_t;
    mode_t      m_mode;
    logic [7:0] exp_b_q[$];
    logic [7:0] exp_r_q[$];
    int         m_wp;
    bit         m_hold_aw, m_hold_ar, m_hold_w;
    logic [7:0] tag = 8'd0;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_pass(input int ch);
        bit p;
        p = 1'b0;
        if (m_mode == M_RUN) begin
            if (ch == 0) p = (exp_b_q.size() < MAX) || m_hold_aw;
            if (ch == 1) p = (exp_r_q.size() < MAX) || m_hold_ar;
            if (ch == 2) p = 1'b1;
        end else if (m_mode == M_DRAIN) begin
            if (ch == 0) p = m_hold_aw;
            if (ch == 1) p = m_hold_ar;
            if (ch == 2) p = (m_wp > 0) || m_hold_w;
        end
        return p;
    endfunction

    function automatic int mode_code(input mode_t m);
        return (m == M_RUN) ? 0 : (m == M_DRAIN) ? 1 : 2;
    endfunction

    // compare process and model advance, away from the active edge
    always @(negedge clk) begin
        bit pa, pr, pw, aw_f, ar_f, wl_f, b_f, rl_f, drained;
        pa = m_pass(0);
        pr = m_pass(1);
        pw = m_pass(2);
        if (chk_en) begin
            check("aw_valid_o", bus.aw_valid_o, bus.aw_valid_i & pa);
            check("aw_ready_o", bus.aw_ready_o, bus.aw_ready_i & pa);
            check("ar_valid_o", bus.ar_valid_o, bus.ar_valid_i & pr);
            check("ar_ready_o", bus.ar_ready_o, bus.ar_ready_i & pr);
            check("w_valid_o",  bus.w_valid_o,  bus.w_valid_i & pw);
            check("w_ready_o",  bus.w_ready_o,  bus.w_ready_i & pw);
            check("isolate_o",  isolate_o,  m_mode == M_ISO);
            check("isolated_o", isolated_o, m_mode == M_ISO);
            check("wr_cnt", dbg_wr, exp_b_q.size());
            check("rd_cnt", dbg_rd, exp_r_q.size());
            check("wpend",  dbg_wp, m_wp);
            check("state",  dbg_state, mode_code(m_mode));
        end
        if (rst) begin
            m_mode = M_RUN;
            exp_b_q.delete();
            exp_r_q.delete();
            m_wp = 0;
            m_hold_aw = 1'b0;
            m_hold_ar = 1'b0;
            m_hold_w  = 1'b0;
        end else begin
            aw_f = bus.aw_valid_i & pa & bus.aw_ready_i;
            ar_f = bus.ar_valid_i & pr & bus.ar_ready_i;
            wl_f = bus.w_valid_i & pw & bus.w_ready_i & bus.w_last_i;
            b_f  = bus.b_valid_i & bus.b_ready_i;
            rl_f = bus.r_valid_i & bus.r_ready_i & bus.r_last_i;
            drained = (exp_b_q.size() == 0) && (exp_r_q.size() == 0) && (m_wp == 0) &&
                      !m_hold_aw && !m_hold_ar && !m_hold_w;
            if (!isolate_req)           m_mode = M_RUN;
            else if (m_mode == M_RUN)   m_mode = M_DRAIN;
            else if (m_mode == M_DRAIN && drained) m_mode = M_ISO;
            if (aw_f) begin exp_b_q.push_back(tag); tag++; end
            if (ar_f) begin exp_r_q.push_back(tag); tag++; end
            if (b_f && exp_b_q.size() > 0) void'(exp_b_q.pop_front());
            if (rl_f && exp_r_q.size() > 0) void'(exp_r_q.pop_front());
            m_wp = m_wp + int'(aw_f) - int'(wl_f);
            m_hold_aw = bus.aw_valid_i & pa & ~bus.aw_ready_i;
            m_hold_ar = bus.ar_valid_i & pr & ~bus.ar_ready_i;
            m_hold_w  = bus.w_valid_i & pw & ~bus.w_ready_i;
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.aw_valid_i = 0; bus.aw_ready_i = 0;
        bus.ar_valid_i = 0; bus.ar_ready_i = 0;
        bus.w_valid_i  = 0; bus.w_ready_i  = 0; bus.w_last_i = 0;
        bus.b_valid_i  = 0; bus.b_ready_i  = 0;
        bus.r_valid_i  = 0; bus.r_ready_i  = 0; bus.r_last_i = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        isolate_req = 0;
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    initial begin
        idle_inputs();
        isolate_req = 0;
        rst = 1;

        // reset with a live AW handshake on the inputs
        bus.aw_valid_i = 1; bus.aw_ready_i = 1;
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_isolate_o", isolate_o, 0);
        check("rst_isolated_o", isolated_o, 0);
        check("rst_aw_valid_o", bus.aw_valid_o, 1);
        check("rst_wr_cnt", dbg_wr, 0);
        rst = 0;
        idle_inputs();
        tick();

        // drain: 3 AW + 2 AR, 3 W-last, then isolate and return responses
        for (int i = 0; i < 3; i++) begin
            bus.aw_valid_i = 1; bus.aw_ready_i = 1;
            bus.ar_valid_i = (i < 2); bus.ar_ready_i = 1;
            tick();
        end
        idle_inputs();
        check("drain_wr3", dbg_wr, 3);
        check("drain_rd2", dbg_rd, 2);
        check("drain_wp3", dbg_wp, 3);
        bus.w_valid_i = 1; bus.w_ready_i = 1; bus.w_last_i = 1;
        repeat (3) tick();
        idle_inputs();
        check("drain_wp0", dbg_wp, 0);
        isolate_req = 1;
        tick();
        check("drain_state", dbg_state, 1);
        bus.b_valid_i = 1; bus.b_ready_i = 1;
        repeat (3) tick();
        idle_inputs();
        check("drain_wr0", dbg_wr, 0);
        bus.r_valid_i = 1; bus.r_ready_i = 1; bus.r_last_i = 1;
        repeat (2) tick();
        idle_inputs();
        check("drain_not_yet", isolated_o, 0);
        tick();
        check("drain_isolated", isolated_o, 1);
        check("drain_isolate", isolate_o, 1);
        isolate_req = 0;
        tick();
        check("release_isolate", isolate_o, 0);
        check("release_state", dbg_state, 0);

        // hold: a started AW survives the isolate request
        bus.aw_valid_i = 1; bus.aw_ready_i = 0;
        tick();
        isolate_req = 1;
        tick();
        check("hold_aw_1", bus.aw_valid_o, 1);
        tick();
        check("hold_aw_2", bus.aw_valid_o, 1);
        bus.aw_ready_i = 1;
        tick();
        check("hold_aw_done", bus.aw_valid_o, 0);
        check("hold_wr1", dbg_wr, 1);
        idle_inputs();
        bus.w_valid_i = 1; bus.w_ready_i = 1; bus.w_last_i = 1;
        tick();
        idle_inputs();
        bus.b_valid_i = 1; bus.b_ready_i = 1;
        tick();
        idle_inputs();
        tick();
        check("hold_isolated", isolated_o, 1);
        isolate_req = 0;
        tick();

        // limit: outstanding AW count saturates at MAX
        do_reset();
        bus.aw_valid_i = 1; bus.aw_ready_i = 1;
        repeat (3) tick();
        bus.b_valid_i = 1; bus.b_ready_i = 1;
        tick();
        check("limit_aw_b_same", dbg_wr, 3);
        bus.b_valid_i = 0; bus.b_ready_i = 0;
        tick();
        check("limit_wr4", dbg_wr, 4);
        check("limit_aw_ready", bus.aw_ready_o, 0);
        tick();
        check("limit_wr4_hold", dbg_wr, 4);
        bus.b_valid_i = 1; bus.b_ready_i = 1;
        tick();
        check("limit_b_only", dbg_wr, 3);
        do_reset();

        // W-first: W last leads AW
        bus.w_valid_i = 1; bus.w_ready_i = 1; bus.w_last_i = 1;
        tick();
        idle_inputs();
        check("wfirst_wp_neg", dbg_wp, -1);
        bus.aw_valid_i = 1; bus.aw_ready_i = 0;
        tick();
        isolate_req = 1;
        tick();
        bus.aw_ready_i = 1;
        tick();
        idle_inputs();
        check("wfirst_wp0", dbg_wp, 0);
        tick();
        tick();
        check("wfirst_wait_b", isolated_o, 0);
        bus.b_valid_i = 1; bus.b_ready_i = 1;
        tick();
        idle_inputs();
        tick();
        check("wfirst_isolated", isolated_o, 1);
        isolate_req = 0;
        tick();

        // abort from DRAIN
        do_reset();
        bus.ar_valid_i = 1; bus.ar_ready_i = 1;
        tick();
        idle_inputs();
        isolate_req = 1;
        tick();
        check("abort_drain", dbg_state, 1);
        isolate_req = 0;
        tick();
        check("abort_run", dbg_state, 0);
        bus.r_valid_i = 1; bus.r_ready_i = 1; bus.r_last_i = 1;
        tick();
        idle_inputs();

        // random traffic under model control
        for (int c = 0; c < 400; c++) begin
            int wr_o;
            wr_o = exp_b_q.size();
            bus.aw_valid_i = 1'($urandom_range(0, 1));
            bus.aw_ready_i = 1'($urandom_range(0, 1));
            bus.ar_valid_i = 1'($urandom_range(0, 1));
            bus.ar_ready_i = 1'($urandom_range(0, 1));
            bus.w_valid_i  = 1'($urandom_range(0, 1));
            bus.w_ready_i  = 1'($urandom_range(0, 1));
            bus.w_last_i   = (m_wp > -2) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.b_valid_i  = (wr_o > 0 && wr_o - m_wp > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.b_ready_i  = 1'($urandom_range(0, 1));
            bus.r_valid_i  = (exp_r_q.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.r_ready_i  = 1'($urandom_range(0, 1));
            bus.r_last_i   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) isolate_req = ~isolate_req;
            tick();
        end
        idle_inputs();
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
